// File: rtl/shared_timer_pkg.sv
// Shared definitions for the shared_timer_arbiter block: FSM encoding and default sizes.
package shared_timer_pkg;

    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_CW   = 4;
    localparam int unsigned ABORT_CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/shared_timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            any_req
);

    localparam int unsigned SW = PW + 1;

    logic [SW-1:0] pos;
    logic          found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, ptr} + SW'(i);
            if (pos >= SW'(NREQ)) begin
                pos = pos - SW'(NREQ);
            end
            if (!found && req[pos[PW-1:0]]) begin
                found               = 1'b1;
                win_oh[pos[PW-1:0]] = 1'b1;
                win_idx             = pos[PW-1:0];
            end
        end
    end

    assign any_req = found;

endmodule

// File: rtl/shared_timer_arbiter.sv
// Round-robin sharing of one loadable down-counter between NREQ requesters.
// Optional ABORT_COUNT_EN adds a saturating count of aborted slots (abort_cnt).
module shared_timer_arbiter
    import shared_timer_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned CW   = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
`ifdef ABORT_COUNT_EN
    output logic [ABORT_CW-1:0]  abort_cnt,
`endif
    output logic [CW-1:0]        cnt_out
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   w_q, w_d;

    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;
    logic            any_req;
    logic [CW-1:0]   len_sel;
    logic [PW-1:0]   next_w;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    // Slot length of the current arbitration winner.
    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                len_sel = len[i*CW +: CW];
            end
        end
    end

    assign next_w = (w_q == PW'(NREQ - 1)) ? '0 : w_q + PW'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d = win_oh;
                    cnt_d = len_sel;
                    w_d   = win_idx;
                    if (len_sel == '0) begin
                        state_d = ST_FIN;
                        done_d  = win_oh;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // A dropped request abandons the slot without a done pulse.
                if ((req & gnt_q) == '0) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = next_w;
                end else if (cnt_q == CW'(1)) begin
                    state_d = ST_FIN;
                    cnt_d   = '0;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = next_w;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
        end
    end

`ifdef ABORT_COUNT_EN
    logic [ABORT_CW-1:0] abort_q;
    logic                abort_evt;

    assign abort_evt = (state_q == ST_RUN) && ((req & gnt_q) == '0);

    // Saturating count of RUN->IDLE aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_q <= '0;
        end else if (abort_evt && (abort_q != '1)) begin
            abort_q <= abort_q + ABORT_CW'(1);
        end
    end

    assign abort_cnt = abort_q;
`endif

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign cnt_out = cnt_q;

endmodule
